// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN core readout path.
// The Q-format threshold uses SNN_FRAC fractional bits.
package snn_pkg;

    localparam int SNN_FRAC  = 12;
    localparam int SNN_Q_ONE = 1 << SNN_FRAC;
    localparam int SNN_CW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } maxer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Per-neuron spike counter with synchronous clear.
// It sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/spike_maxer.sv
// Winner-take-all readout: counts spikes per neuron, then scans for the max.
// Build option SPIKE_MAXER_TIE_HIGH_EN makes ties go to the highest index.
module spike_maxer
    import snn_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = 24,
    parameter int CW   = SNN_CW,
    parameter int FRAC = SNN_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_core_img,
    input  logic [N-1:0]         ops,
    input  logic                 TU_incre,
    input  logic                 done_core_img,
    output logic                 valid_maxing,
    output logic [W-1:0]         threshold_maxer,
    output logic [$clog2(N)-1:0] winner,
    output logic                 no_spike,
    output logic                 busy
);

    localparam int IW = $clog2(N);

    maxer_state_t  state;
    logic [CW-1:0] cnt [N];
    logic [IW-1:0] idx;
    logic [IW-1:0] best_idx;
    logic [CW-1:0] best;
    logic [CW-1:0] cur;
    logic [W-1:0]  best_w;
    logic          cnt_inc;
    logic          take;
    logic          last;

    // start wins over a coincident time unit, so its spikes are dropped
    assign cnt_inc = (state == ST_COUNT) && TU_incre && !start_core_img;

    for (genvar g = 0; g < N; g++) begin : g_cnt
        sat_counter #(.CW(CW)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (start_core_img),
            .inc (cnt_inc && ops[g]),
            .q   (cnt[g])
        );
    end

    assign cur    = cnt[idx];
    assign last   = (idx == IW'(N - 1));
    assign best_w = W'(best);

`ifdef SPIKE_MAXER_TIE_HIGH_EN
    assign take = (cur >= best);
`else
    assign take = (cur > best);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            idx             <= '0;
            best            <= '0;
            best_idx        <= '0;
            valid_maxing    <= 1'b0;
            threshold_maxer <= '0;
            winner          <= '0;
            no_spike        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            valid_maxing <= 1'b0;
            busy         <= (state == ST_COUNT) || (state == ST_SCAN);
            if (start_core_img) begin
                state    <= ST_COUNT;
                idx      <= '0;
                best     <= '0;
                best_idx <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                    end
                    ST_COUNT: begin
                        if (done_core_img) begin
                            state    <= ST_SCAN;
                            idx      <= '0;
                            best     <= '0;
                            best_idx <= '0;
                        end
                    end
                    ST_SCAN: begin
                        if (take) begin
                            best     <= cur;
                            best_idx <= idx;
                        end
                        if (last) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        valid_maxing    <= 1'b1;
                        winner          <= best_idx;
                        threshold_maxer <= best_w << FRAC;
                        no_spike        <= (best == '0);
                        state           <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_maxer.sv
// Self-checking bench for spike_maxer: vector table plus scoreboard.
// Honours SPIKE_MAXER_TIE_HIGH_EN for tie expectations.
module tb_spike_maxer;
    import snn_pkg::*;

`ifdef SPIKE_MAXER_TIE_HIGH_EN
    localparam bit TIE_HI = 1'b1;
`else
    localparam bit TIE_HI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_core_img;
    logic [7:0]  ops;
    logic        TU_incre;
    logic        done_core_img;
    logic        valid_maxing;
    logic [23:0] threshold_maxer;
    logic [2:0]  winner;
    logic        no_spike;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] ops_a;
        int         n_a;
        logic [7:0] ops_b;
        int         n_b;
        bit         tu_done;
        logic [2:0] w;
        int         cnt;
        logic       ns;
    } vec_t;

    typedef struct {
        int          id;
        int          cyc;
        logic [2:0]  w;
        logic [23:0] thr;
        logic        ns;
    } exp_t;

    exp_t q[$];
    vec_t vecs[7];

    spike_maxer dut (
        .clk             (clk),
        .rst             (rst),
        .start_core_img  (start_core_img),
        .ops             (ops),
        .TU_incre        (TU_incre),
        .done_core_img   (done_core_img),
        .valid_maxing    (valid_maxing),
        .threshold_maxer (threshold_maxer),
        .winner          (winner),
        .no_spike        (no_spike),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s id=%0d got=%0d want=%0d", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_maxing) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid cyc=%0d got=1 want=0", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", e.id, cyc, e.cyc);
                chk("winner", e.id, 32'(winner), 32'(e.w));
                chk("threshold", e.id, 32'(threshold_maxer), 32'(e.thr));
                chk("no_spike", e.id, 32'(no_spike), 32'(e.ns));
                chk("busy_low", e.id, 32'(busy), 0);
            end
        end
    end

    task automatic begin_img();
        @(negedge clk);
        start_core_img = 1'b1;
        TU_incre       = 1'b1;
        ops            = 8'hFF;
        @(negedge clk);
        start_core_img = 1'b0;
        TU_incre       = 1'b0;
        ops            = 8'h00;
    endtask

    task automatic pulses(input logic [7:0] o, input int n);
        for (int k = 0; k < n; k++) begin
            TU_incre = 1'b1;
            ops      = o;
            @(negedge clk);
        end
        TU_incre = 1'b0;
        ops      = 8'h00;
    endtask

    task automatic end_img(input int id, input bit tu, input logic [7:0] o,
                           input bit push, input logic [2:0] w,
                           input int cnt, input logic ns);
        exp_t e;
        TU_incre      = tu;
        ops           = tu ? o : 8'h00;
        done_core_img = 1'b1;
        if (push) begin
            e.id  = id;
            e.cyc = cyc + 10;
            e.w   = w;
            e.thr = 24'(cnt * SNN_Q_ONE);
            e.ns  = ns;
            q.push_back(e);
        end
        @(negedge clk);
        done_core_img = 1'b0;
        TU_incre      = 1'b0;
        ops           = 8'h00;
    endtask

    task automatic wait_result(input int id);
        int k;
        k = 0;
        while (q.size() > 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout id=%0d got=none want=valid", id);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'h04, 10, 8'h00, 0, 1'b0, 3'd2, 10, 1'b0};
        vecs[1] = '{8'h22, 3, 8'h00, 0, 1'b0, TIE_HI ? 3'd5 : 3'd1, 3, 1'b0};
        vecs[2] = '{8'h00, 5, 8'h00, 0, 1'b0, TIE_HI ? 3'd7 : 3'd0, 0, 1'b1};
        vecs[3] = '{8'h80, 300, 8'h00, 0, 1'b0, 3'd7, 255, 1'b0};
        vecs[4] = '{8'h08, 4, 8'h08, 0, 1'b1, 3'd3, 5, 1'b0};
        vecs[5] = '{8'h01, 2, 8'h41, 5, 1'b0, 3'd0, 7, 1'b0};
        vecs[6] = '{8'h81, 3, 8'h80, 1, 1'b0, 3'd7, 4, 1'b0};

        rst            = 1'b1;
        start_core_img = 1'b0;
        TU_incre       = 1'b0;
        done_core_img  = 1'b0;
        ops            = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_valid", -1, 32'(valid_maxing), 0);
        chk("rst_thr", -1, 32'(threshold_maxer), 0);
        chk("rst_winner", -1, 32'(winner), 0);
        chk("rst_nospike", -1, 32'(no_spike), 0);
        chk("rst_busy", -1, 32'(busy), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            begin_img();
            pulses(vecs[i].ops_a, vecs[i].n_a);
            pulses(vecs[i].ops_b, vecs[i].n_b);
            if (i == 0) chk("busy_count", i, 32'(busy), 1);
            end_img(i, vecs[i].tu_done, vecs[i].ops_b, 1'b1,
                    vecs[i].w, vecs[i].cnt, vecs[i].ns);
            wait_result(i);
        end

        begin_img();
        pulses(8'h01, 5);
        end_img(10, 1'b0, 8'h00, 1'b0, 3'd0, 0, 1'b0);
        repeat (3) @(negedge clk);
        begin_img();
        pulses(8'h10, 2);
        end_img(11, 1'b0, 8'h00, 1'b1, 3'd4, 2, 1'b0);
        wait_result(11);

        begin_img();
        pulses(8'h02, 4);
        chk("busy_pre_rst", 20, 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_valid", 20, 32'(valid_maxing), 0);
        chk("rr_thr", 20, 32'(threshold_maxer), 0);
        chk("rr_winner", 20, 32'(winner), 0);
        chk("rr_nospike", 20, 32'(no_spike), 0);
        chk("rr_busy", 20, 32'(busy), 0);
        pulses(8'hFF, 3);
        end_img(21, 1'b0, 8'h00, 1'b0, 3'd0, 0, 1'b0);
        repeat (15) @(negedge clk);
        chk("idle_busy", 21, 32'(busy), 0);
        chk("idle_thr", 21, 32'(threshold_maxer), 0);

        begin_img();
        end_img(22, 1'b0, 8'h00, 1'b1, TIE_HI ? 3'd7 : 3'd0, 0, 1'b1);
        wait_result(22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
